// File: rtl/treeval_host_bridge_if.sv
// Handshake bundle between the host, treeval_host_bridge and treeval_controller.
// The bridge connects through the slave modport. The bench, acting as host and
// controller, uses the master modport.
interface treeval_host_bridge_if #(
  parameter int W_MSG = 64
);
  logic             host_wr_valid;
  logic             host_wr_ready;
  logic [W_MSG-1:0] host_wr_data;
  logic             msg_rdy;
  logic [W_MSG-1:0] msg;
  logic             msg_ack;
  logic             resp_rdy;
  logic [W_MSG-1:0] resp;
  logic             resp_ack;
  logic             host_rd_valid;
  logic             host_rd_ready;
  logic [W_MSG-1:0] host_rd_data;

  modport slave (
    input  host_wr_valid, host_wr_data, msg_ack, resp_rdy, resp, host_rd_ready,
    output host_wr_ready, msg_rdy, msg, resp_ack, host_rd_valid, host_rd_data
  );

  modport master (
    output host_wr_valid, host_wr_data, msg_ack, resp_rdy, resp, host_rd_ready,
    input  host_wr_ready, msg_rdy, msg, resp_ack, host_rd_valid, host_rd_data
  );
endinterface

// File: rtl/treeval_host_bridge.sv
// Host ingress/egress bridge for treeval_controller. A command FIFO feeds the
// controller one message at a time over rdy/ack, with ack-timeout dropping.
// A one-entry holding register captures controller results for the host.
module treeval_host_bridge #(
  parameter int W_MSG   = 64,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  treeval_host_bridge_if.slave  bus,
  output logic                  busy,
  output logic                  err_timeout,
  input  logic                  clr_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} send_state_t;
  typedef enum logic {R_IDLE, R_DRAIN} resp_state_t;

  logic [W_MSG-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             head_vld;
  logic             push, pop, load, drop, tmr_inc;
  logic [TW-1:0]    timer;
  logic [W_MSG-1:0] msg_q;
  send_state_t      s_state, s_next;

  resp_state_t      r_state, r_next;
  logic             capture;
  logic             resp_ack_q;
  logic             rd_valid;
  logic [W_MSG-1:0] rd_data;

  // Ready is held low while reset is asserted, then reflects free space.
  assign bus.host_wr_ready = rst & (count != FULL_CNT);
  assign push              = bus.host_wr_valid & bus.host_wr_ready;

  // FIFO storage carries data only and needs no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.host_wr_data;
  end

  // FIFO pointers and occupancy; head_vld lags count by one cycle so the send
  // FSM loads from a head entry that was written at least one edge earlier.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      head_vld <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      head_vld <= (count != '0);
    end
  end

  // Send FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) s_state <= S_IDLE;
    else      s_state <= s_next;
  end

  // Send FSM next state: present head, pop on ack or on timeout, then one idle gap.
  always_comb begin
    s_next  = s_state;
    load    = 1'b0;
    pop     = 1'b0;
    drop    = 1'b0;
    tmr_inc = 1'b0;
    case (s_state)
      S_IDLE: begin
        if (head_vld) begin
          load   = 1'b1;
          s_next = S_SEND;
        end
      end
      S_SEND: begin
        if (bus.msg_ack) begin
          pop    = 1'b1;
          s_next = S_GAP;
        end else if (timer == TMR_LAST) begin
          pop    = 1'b1;
          drop   = 1'b1;
          s_next = S_GAP;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      S_GAP:   s_next = S_IDLE;
      default: s_next = S_IDLE;
    endcase
  end

  // Outgoing message register and ack-timeout counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msg_q <= '0;
      timer <= '0;
    end else if (load) begin
      msg_q <= mem[rd_ptr];
      timer <= '0;
    end else if (tmr_inc) begin
      timer <= timer + 1'b1;
    end
  end

  assign bus.msg_rdy = (s_state == S_SEND);
  assign bus.msg     = msg_q;
  assign busy        = (count != '0) | (s_state != S_IDLE);

  // Response FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= R_IDLE;
    else      r_state <= r_next;
  end

  // Response FSM: capture once into an empty holder, then wait for rdy to drop.
  always_comb begin
    r_next  = r_state;
    capture = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (bus.resp_rdy && !rd_valid) begin
          capture = 1'b1;
          r_next  = R_DRAIN;
        end
      end
      R_DRAIN: if (!bus.resp_rdy) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Holding register, one-cycle ack pulse and host-side drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_ack_q <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
    end else begin
      resp_ack_q <= capture;
      if (capture) begin
        rd_valid <= 1'b1;
        rd_data  <= bus.resp;
      end else if (rd_valid && bus.host_rd_ready) begin
        rd_valid <= 1'b0;
      end
    end
  end

  assign bus.resp_ack      = resp_ack_q;
  assign bus.host_rd_valid = rd_valid;
  assign bus.host_rd_data  = rd_data;

  // Sticky timeout flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         err_timeout <= 1'b0;
    else if (drop)    err_timeout <= 1'b1;
    else if (clr_err) err_timeout <= 1'b0;
  end
endmodule

// File: tb/tb_treeval_host_bridge.sv
// Bench for treeval_host_bridge: host and controller models with scoreboards
// for outgoing commands and captured responses.
module tb_treeval_host_bridge;
  localparam int TIMEOUT = 16;

  logic clk;
  logic rst;
  logic busy, err_timeout, clr_err;

  treeval_host_bridge_if #(.W_MSG(64)) bus ();

  treeval_host_bridge #(.W_MSG(64), .DEPTH(8), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .err_timeout (err_timeout),
    .clr_err     (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [63:0] expq [$];
  logic [63:0] respq [$];
  int ack_at  = 0;
  bit in_rst  = 1'b0;
  int acc_cnt = 0;
  int drop_cnt = 0;
  int rack_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Controller model on the command side: checks order/stability, drives ack.
  initial begin
    int run = 0;
    int low = 0;
    logic [63:0] cur = '0;
    bus.msg_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.msg_rdy) begin
        run++;
        if (run == 1) begin
          chk("gap", 64'(low >= 1), 1);
          chk("msg_expected", 64'(expq.size() != 0), 1);
          if (expq.size() != 0) cur = expq.pop_front();
          chk("msg", bus.msg, cur);
        end else begin
          chk("msg_hold", bus.msg, cur);
        end
        bus.msg_ack = (ack_at != 0) && (run >= ack_at);
        low = 0;
      end else begin
        if (run != 0 && !in_rst) begin
          if (bus.msg_ack) acc_cnt++;
          else begin
            drop_cnt++;
            chk("timeout_len", run, TIMEOUT);
          end
        end
        run = 0;
        low++;
        bus.msg_ack = 1'b0;
      end
    end
  end

  // Response ack monitor: counts pulses and checks they last one cycle.
  initial begin
    bit prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.resp_ack) begin
        rack_cnt++;
        chk("resp_ack_width", prev, 0);
      end
      prev = bus.resp_ack;
    end
  end

  // Call at a negedge; drives one cycle of valid and returns at the next negedge.
  task automatic push(input logic [63:0] d, input bit accept);
    bus.host_wr_valid = 1'b1;
    bus.host_wr_data  = d;
    chk("wr_ready", bus.host_wr_ready, accept);
    if (accept) expq.push_back(d);
    @(negedge clk);
    bus.host_wr_valid = 1'b0;
  endtask

  task automatic host_read();
    logic [63:0] e;
    chk("rd_valid_before", bus.host_rd_valid, 1);
    e = (respq.size() != 0) ? respq.pop_front() : 64'hBAD0_BAD0_BAD0_BAD0;
    chk("rd_data", bus.host_rd_data, e);
    bus.host_rd_ready = 1'b1;
    @(negedge clk);
    bus.host_rd_ready = 1'b0;
    chk("rd_valid_after", bus.host_rd_valid, 0);
  endtask

  task automatic wait_acc(input string tag, input int target);
    int k = 0;
    while (acc_cnt < target && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'(acc_cnt >= target), 1);
  endtask

  task automatic wait_rdy(input string tag, input logic lvl);
    int k = 0;
    while (bus.msg_rdy !== lvl && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk(tag, bus.msg_rdy, lvl);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    bus.host_wr_valid = 1'b0;
    bus.host_wr_data  = '0;
    bus.resp_rdy      = 1'b0;
    bus.resp          = '0;
    bus.host_rd_ready = 1'b0;
    clr_err           = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk("rst_wr_ready", bus.host_wr_ready, 0);
    chk("rst_msg_rdy", bus.msg_rdy, 0);
    chk("rst_msg", bus.msg, 0);
    chk("rst_resp_ack", bus.resp_ack, 0);
    chk("rst_rd_valid", bus.host_rd_valid, 0);
    chk("rst_rd_data", bus.host_rd_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("wr_ready_after_rst", bus.host_wr_ready, 1);

    // Single push, acked on the third rdy cycle, with push-to-rdy latency.
    ack_at = 3;
    push(64'h8000_0000_0000_0007, 1'b1);
    chk("lat_t0", bus.msg_rdy, 0);
    @(negedge clk);
    chk("lat_t1", bus.msg_rdy, 0);
    @(negedge clk);
    chk("lat_t2", bus.msg_rdy, 1);
    wait_acc("single_acc", 1);
    repeat (3) @(negedge clk);
    chk("single_pops", acc_cnt, 1);
    chk("single_busy", busy, 0);
    chk("single_err", err_timeout, 0);

    // FIFO fill: eight back-to-back, ninth refused, then ack each at once.
    ack_at = 0;
    for (int i = 0; i < 8; i++) push(64'h4000_0000_0000_0010 + 64'(i), 1'b1);
    chk("full_ready", bus.host_wr_ready, 0);
    push(64'h4000_0000_0000_DEAD, 1'b0);
    ack_at = 1;
    wait_acc("fill_acc", 9);
    repeat (4) @(negedge clk);
    chk("fill_count", acc_cnt, 9);
    chk("fill_busy", busy, 0);
    chk("fill_queue_empty", expq.size(), 0);

    // Timeout: first message dropped after 16 rdy cycles, second presented.
    ack_at = 0;
    push(64'hC000_0000_0000_00A1, 1'b1);
    push(64'hC000_0000_0000_00B2, 1'b1);
    begin
      int k = 0;
      while (drop_cnt < 1 && k < 60) begin
        @(negedge clk);
        k++;
      end
    end
    chk("to_dropped", drop_cnt, 1);
    chk("to_err_set", err_timeout, 1);
    ack_at = 1;
    wait_acc("to_next_acc", 10);
    repeat (3) @(negedge clk);
    chk("to_err_sticky", err_timeout, 1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("to_err_clr", err_timeout, 0);

    // Timeout drop while clear is held: set wins for that cycle.
    ack_at = 0;
    clr_err = 1'b1;
    push(64'hC000_0000_0000_00C3, 1'b1);
    wait_rdy("sw_rdy_hi", 1'b1);
    wait_rdy("sw_rdy_lo", 1'b0);
    chk("sw_err_set_wins", err_timeout, 1);
    @(negedge clk);
    chk("sw_err_clr_next", err_timeout, 0);
    clr_err = 1'b0;
    ack_at = 1;
    repeat (3) @(negedge clk);

    // Response capture and backpressure.
    bus.resp_rdy = 1'b1;
    bus.resp = 64'h0000_0000_0000_0107;
    respq.push_back(64'h0000_0000_0000_0107);
    @(negedge clk);
    chk("cap_ack", bus.resp_ack, 1);
    chk("cap_valid", bus.host_rd_valid, 1);
    chk("cap_data", bus.host_rd_data, 64'h107);
    @(negedge clk);
    chk("cap_ack_low", bus.resp_ack, 0);
    bus.resp_rdy = 1'b0;
    @(negedge clk);
    bus.resp_rdy = 1'b1;
    bus.resp = 64'h0000_0000_0000_2222;
    respq.push_back(64'h0000_0000_0000_2222);
    a0 = rack_cnt;
    repeat (4) @(negedge clk);
    chk("bp_noack", rack_cnt, a0);
    chk("bp_data_kept", bus.host_rd_data, 64'h107);
    host_read();
    @(negedge clk);
    chk("bp_ack_after_read", bus.resp_ack, 1);
    chk("bp_data2", bus.host_rd_data, 64'h2222);
    bus.resp_rdy = 1'b0;
    @(negedge clk);
    host_read();

    // Held rdy: exactly one capture while the controller keeps rdy high.
    bus.resp_rdy = 1'b1;
    bus.resp = 64'h0000_0000_0000_0333;
    respq.push_back(64'h0000_0000_0000_0333);
    a0 = rack_cnt;
    repeat (6) @(negedge clk);
    host_read();
    repeat (3) @(negedge clk);
    chk("held_one_ack", rack_cnt - a0, 1);
    chk("held_no_recapture", bus.host_rd_valid, 0);
    bus.resp_rdy = 1'b0;
    @(negedge clk);
    chk("resp_queue_empty", respq.size(), 0);

    // Asynchronous reset mid-send with three messages queued.
    ack_at = 0;
    push(64'h4000_0000_0000_0E01, 1'b1);
    push(64'h4000_0000_0000_0E02, 1'b1);
    push(64'h4000_0000_0000_0E03, 1'b1);
    wait_rdy("rm_rdy_hi", 1'b1);
    repeat (2) @(negedge clk);
    in_rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rm_rdy_async", bus.msg_rdy, 0);
    @(negedge clk);
    rst = 1'b1;
    expq.delete();
    @(negedge clk);
    chk("rm_busy", busy, 0);
    chk("rm_wr_ready", bus.host_wr_ready, 1);
    repeat (5) @(negedge clk);
    chk("rm_no_resend", bus.msg_rdy, 0);
    in_rst = 1'b0;

    chk("final_acc", acc_cnt, 10);
    chk("final_drop", drop_cnt, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
